// File: rtl/xmt_buf.sv
// xmt_buf: byte FIFO in front of the serial line transmitter.
// Host bytes are queued here and handed to the transmitter one at a time
// over its load/empty handshake. This way a burst of host writes is not lost
// while the line is busy.
module xmt_buf #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [7:0]            wr_data,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   input  logic                  clr_overflow,
   output logic                  busy,
   output logic                  xmt_load,
   output logic [7:0]            xmt_data,
   input  logic                  xmt_empty
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;

   // WAIT_BUSY is needed because the transmitter's empty flag is still high
   // during the LOAD cycle. Without it, that stale flag would look like completion.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t state, state_next;

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic                  pop;
   logic                  push;
   logic                  drop;

   // level never exceeds DEPTH, so its top bit alone marks a full FIFO.
   assign full = level[DEPTH_LOG2];
   assign busy = (state != IDLE) || (level != '0);

   // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
   assign push = wr_en && (!full || pop);
   assign drop = wr_en && full && !pop;

   // Next-state logic and pop decision for the transmitter handshake
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_next = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if ((level != '0) && xmt_empty) begin
               pop        = 1'b1;
               state_next = LOAD;
            end
         end
         LOAD:      state_next = WAIT_BUSY;
         WAIT_BUSY: if (!xmt_empty) state_next = WAIT_DONE;
         WAIT_DONE: if (xmt_empty)  state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // Controller state register and the registered load/data outputs
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state    <= IDLE;
         xmt_load <= 1'b0;
         xmt_data <= 8'h00;
      end else begin
         state    <= state_next;
         xmt_load <= pop;
         if (pop) xmt_data <= mem[rd_ptr];
      end
   end

   // FIFO pointers and occupancy counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Byte storage
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; pointers and level define which entries are valid.
      if (push) mem[wr_ptr] <= wr_data;
   end

   // Sticky overflow flag; a dropped write wins over a simultaneous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset)             overflow <= 1'b0;
      else if (drop)         overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
   end

endmodule

// File: tb/tb_xmt_buf.sv
// tb_xmt_buf: drives xmt_buf with a simple transmitter model and compares
// every cycle against a queue-based reference of the buffer's behaviour.
module tb_xmt_buf;

   localparam int DL    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [7:0]    wr_data;
   logic          full;
   logic [DL:0]   level;
   logic          overflow;
   logic          clr_overflow;
   logic          busy;
   logic          xmt_load;
   logic [7:0]    xmt_data;
   logic          xmt_empty;

   always #5 clk = ~clk;

   xmt_buf #(.DEPTH_LOG2(DL)) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .full         (full),
      .level        (level),
      .overflow     (overflow),
      .clr_overflow (clr_overflow),
      .busy         (busy),
      .xmt_load     (xmt_load),
      .xmt_data     (xmt_data),
      .xmt_empty    (xmt_empty)
   );

   int total = 0;
   int bad   = 0;

   // reference model: queued bytes plus the progress of the byte on the line
   logic [7:0] q[$];
   bit         m_ovf;
   bit         m_load;
   bit         m_inflight;
   bit         m_accepted;
   logic [7:0] m_data;

   // transmitter model
   bit tx_hold;
   int tx_cnt;
   int tx_lo;
   int tx_hi;

   // bytes seen on the load strobe and bytes each test expects, in order
   logic [7:0] got[$];
   logic [7:0] want[$];
   int         peak;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf      = 0;
      m_load     = 0;
      m_inflight = 0;
      m_accepted = 0;
      m_data     = 8'h00;
   endtask

   // Predict the effect of the coming rising edge from the inputs now applied.
   task automatic model_edge();
      bit do_pop;
      bit ovf_set;
      do_pop = !m_inflight && (q.size() != 0) && (xmt_empty == 1'b1);
      if (m_inflight) begin
         if (m_load) begin
            // strobe cycle: empty is still stale, nothing learned
         end else if (!m_accepted) begin
            if (xmt_empty == 1'b0) m_accepted = 1;
         end else if (xmt_empty == 1'b1) begin
            m_inflight = 0;
         end
      end
      m_load = do_pop;
      if (do_pop) begin
         m_data     = q.pop_front();
         m_inflight = 1;
         m_accepted = 0;
      end
      ovf_set = 0;
      if (wr_en) begin
         if (q.size() < DEPTH) q.push_back(wr_data);
         else                  ovf_set = 1;
      end
      if (ovf_set)           m_ovf = 1;
      else if (clr_overflow) m_ovf = 0;
   endtask

   task automatic compare();
      check("level",    32'(level),    32'(q.size()));
      check("full",     32'(full),     32'(q.size() == DEPTH));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("busy",     32'(busy),     32'(m_inflight || (q.size() != 0)));
      check("xmt_load", 32'(xmt_load), 32'(m_load));
      check("xmt_data", 32'(xmt_data), 32'(m_data));
   endtask

   // One clock cycle: transmitter reacts, inputs applied, model advanced, outputs compared.
   task automatic step(input logic w, input logic [7:0] d, input logic clr);
      if (tx_hold) begin
         xmt_empty = 1'b0;
      end else if (xmt_empty && xmt_load) begin
         xmt_empty = 1'b0;
         tx_cnt    = $urandom_range(tx_hi, tx_lo);
      end else if (!xmt_empty) begin
         if (tx_cnt == 0) xmt_empty = 1'b1;
         else             tx_cnt--;
      end
      wr_en        = w;
      wr_data      = d;
      clr_overflow = clr;
      model_edge();
      @(negedge clk);
      compare();
      if (xmt_load === 1'b1) begin
         got.push_back(xmt_data);
         check("load_while_line_busy", 32'(xmt_empty), 32'd1);
      end
      if (int'(level) > peak) peak = int'(level);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((m_inflight || (q.size() != 0) || !xmt_empty) && (n < 3000)) begin
         step(1'b0, 8'h00, 1'b0);
         n++;
      end
      check({name, "_drain_in_time"}, 32'(n < 3000), 32'd1);
   endtask

   task automatic check_sent(input string name);
      check({name, "_count"}, 32'(got.size()), 32'(want.size()));
      for (int i = 0; i < want.size(); i++) begin
         check({name, "_byte"}, (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(want[i]));
      end
      got.delete();
      want.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset        = 1'b1;
      wr_en        = 1'b0;
      wr_data      = 8'h00;
      clr_overflow = 1'b0;
      xmt_empty    = 1'b1;
      tx_hold      = 0;
      tx_cnt       = 0;
      tx_lo        = 2;
      tx_hi        = 2;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_level",    32'(level),    32'd0);
      check("rst_full",     32'(full),     32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_load",     32'(xmt_load), 32'd0);
      check("rst_data",     32'(xmt_data), 32'h00);
      reset = 1'b0;

      // 1: single byte, load strobe two edges after the write
      tx_lo = 4; tx_hi = 4;
      step(1'b1, 8'hA5, 1'b0);
      check("t1_level_after_write", 32'(level), 32'd1);
      step(1'b0, 8'h00, 1'b0);
      check("t1_load", 32'(xmt_load), 32'd1);
      check("t1_data", 32'(xmt_data), 32'hA5);
      check("t1_level_after_pop", 32'(level), 32'd0);
      step(1'b0, 8'h00, 1'b0);
      check("t1_load_one_cycle", 32'(xmt_load), 32'd0);
      check("t1_busy", 32'(busy), 32'd1);
      want.push_back(8'hA5);
      drain("t1");
      check_sent("t1");

      // 2: five back-to-back writes against an 11-cycle transmitter
      tx_lo = 11; tx_hi = 11;
      peak  = 0;
      for (int i = 1; i <= 5; i++) begin
         step(1'b1, 8'(i), 1'b0);
         want.push_back(8'(i));
      end
      drain("t2");
      check("t2_peak", 32'(peak), 32'd4);
      check_sent("t2");

      // 3: line stalled, overfill, clear overflow, then release
      tx_lo = 2; tx_hi = 3;
      tx_hold = 1;
      step(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 17; i++) begin
         step(1'b1, 8'h10 + 8'(i), 1'b0);
         if (i < 16) want.push_back(8'h10 + 8'(i));
         if (i == 15) begin
            check("t3_full", 32'(full), 32'd1);
            check("t3_level16", 32'(level), 32'd16);
            check("t3_no_overflow_yet", 32'(overflow), 32'd0);
         end
      end
      check("t3_overflow", 32'(overflow), 32'd1);
      check("t3_level_kept", 32'(level), 32'd16);
      step(1'b1, 8'h99, 1'b1);
      check("t3_overflow_wins_clear", 32'(overflow), 32'd1);
      step(1'b0, 8'h00, 1'b1);
      check("t3_overflow_cleared", 32'(overflow), 32'd0);
      tx_hold = 0;
      drain("t3");
      check_sent("t3");

      // 4: write into a full FIFO in the same cycle as a pop
      tx_hold = 1;
      step(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 8'h40 + 8'(i), 1'b0);
         want.push_back(8'h40 + 8'(i));
      end
      check("t4_full", 32'(full), 32'd1);
      tx_hold = 0;
      step(1'b1, 8'hEE, 1'b0);
      want.push_back(8'hEE);
      check("t4_level", 32'(level), 32'd16);
      check("t4_overflow", 32'(overflow), 32'd0);
      check("t4_load", 32'(xmt_load), 32'd1);
      check("t4_data", 32'(xmt_data), 32'h40);
      drain("t4");
      check_sent("t4");

      // 5: asynchronous reset while a byte is on the line and three are queued
      tx_lo = 20; tx_hi = 20;
      for (int i = 0; i < 4; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
      n = 0;
      while (!(m_inflight && m_accepted && !m_load) && (n < 50)) begin
         step(1'b0, 8'h00, 1'b0);
         n++;
      end
      check("t5_reached_wait", 32'(n < 50), 32'd1);
      check("t5_queued", 32'(level), 32'd3);
      #2 reset = 1'b1;
      #1;
      check("t5_level", 32'(level), 32'd0);
      check("t5_load", 32'(xmt_load), 32'd0);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_full", 32'(full), 32'd0);
      check("t5_data", 32'(xmt_data), 32'h00);
      model_reset();
      xmt_empty = 1'b1;
      tx_cnt    = 0;
      got.delete();
      want.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 30; i++) step(1'b0, 8'h00, 1'b0);
      check("t5_no_load_after_reset", 32'(got.size()), 32'd0);

      // random traffic, including overflow and clears
      tx_lo = 1; tx_hi = 6;
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 15) == 0));
      end
      drain("rand");
      step(1'b0, 8'h00, 1'b1);
      got.delete();
      want.delete();

      // 6: 40 paced bytes, pointers wrap twice
      tx_lo = 1; tx_hi = 3;
      n = 0;
      for (int c = 0; (c < 4000) && (n < 40); c++) begin
         if ((q.size() < DEPTH) && ($urandom_range(0, 1) == 1)) begin
            logic [7:0] b;
            b = 8'($urandom);
            want.push_back(b);
            step(1'b1, b, 1'b0);
            n++;
         end else begin
            step(1'b0, 8'h00, 1'b0);
         end
      end
      check("t6_all_written", 32'(n), 32'd40);
      drain("t6");
      check("t6_no_overflow", 32'(overflow), 32'd0);
      check_sent("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
